// File: rtl/control_cmd_encoder.sv
// Serializes one high-level command into opcode + operand bytes for the control unit's byte input.
// Optional per-byte ack timeout is enabled by defining CMD_ENC_ACK_TIMEOUT_EN.

`ifndef COMMAND_WRITE_BLOCK_INSTR
`define COMMAND_WRITE_BLOCK_INSTR   8'h01
`define COMMAND_WRITE_BLOCK_REG_0   8'h02
`define COMMAND_WRITE_BLOCK_REG_1   8'h03
`define COMMAND_ALLOC_DELAY         8'h04
`define COMMAND_SET_INPUT_GAIN      8'h05
`define COMMAND_SET_OUTPUT_GAIN     8'h06
`define COMMAND_BEGIN_PROGRAM       8'h07
`define COMMAND_END_PROGRAM         8'h08
`define COMMAND_COMMIT_REG_UPDATES  8'h09
`define COMMAND_UPDATE_BLOCK_REG_0  8'h0A
`define COMMAND_UPDATE_BLOCK_REG_1  8'h0B
`endif
`ifndef BLOCK_INSTR_WIDTH
`define BLOCK_INSTR_WIDTH 32
`endif

module control_cmd_encoder #(
  parameter int unsigned n_blocks    = 256,
  parameter int unsigned data_width  = 16,
  parameter int unsigned ack_timeout = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [7:0]                    req_command,
  input  logic [$clog2(n_blocks)-1:0]   req_block,
  input  logic [data_width-1:0]         req_data,
  input  logic [`BLOCK_INSTR_WIDTH-1:0] req_instr,
  input  logic [2*data_width-1:0]       req_delay_size,
  input  logic [2*data_width-1:0]       req_init_delay,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  input  logic                          next,
  output logic                          done,
  output logic                          req_error,
  output logic                          busy
);

  localparam int unsigned BlkBytes  = (n_blocks > 256) ? 2 : 1;
  localparam int unsigned DataBytes = (data_width == 24) ? 3 : 2;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [55:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  total_q, total_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Fields left-justified so each can be shifted into place behind the block field.
  logic [15:0] blk_lj;
  logic [23:0] data_lj;
  logic [31:0] instr32;
  logic [47:0] operands;
  logic [2:0]  cmd_total;
  logic        cmd_known;

  always_comb begin
    blk_lj    = 16'(req_block) << (8 * (2 - BlkBytes));
    data_lj   = 24'(req_data) << (8 * (3 - DataBytes));
    instr32   = 32'(req_instr);
    operands  = '0;
    cmd_total = 3'd0;
    cmd_known = 1'b1;
    case (req_command)
      `COMMAND_WRITE_BLOCK_INSTR: begin
        operands  = {blk_lj, 32'h0} | ({instr32, 16'h0} >> (8 * BlkBytes));
        cmd_total = 3'(1 + BlkBytes + 4);
      end
      `COMMAND_WRITE_BLOCK_REG_0, `COMMAND_WRITE_BLOCK_REG_1,
      `COMMAND_UPDATE_BLOCK_REG_0, `COMMAND_UPDATE_BLOCK_REG_1: begin
        operands  = {blk_lj, 32'h0} | ({data_lj, 24'h0} >> (8 * BlkBytes));
        cmd_total = 3'(1 + BlkBytes + DataBytes);
      end
      `COMMAND_ALLOC_DELAY: begin
        operands  = {24'(req_delay_size), 24'(req_init_delay)};
        cmd_total = 3'd7;
      end
      `COMMAND_SET_INPUT_GAIN, `COMMAND_SET_OUTPUT_GAIN: begin
        operands  = {data_lj, 24'h0};
        cmd_total = 3'(1 + DataBytes);
      end
      `COMMAND_BEGIN_PROGRAM, `COMMAND_COMMIT_REG_UPDATES, `COMMAND_END_PROGRAM: begin
        cmd_total = 3'd1;
      end
      default: cmd_known = 1'b0;
    endcase
  end

`ifdef CMD_ENC_ACK_TIMEOUT_EN
  localparam int unsigned AckW = $clog2(ack_timeout + 1);
  logic [AckW-1:0] ack_cnt_q, ack_cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      cnt_q     <= '0;
      total_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef CMD_ENC_ACK_TIMEOUT_EN
      ack_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      total_q   <= total_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef CMD_ENC_ACK_TIMEOUT_EN
      ack_cnt_q <= ack_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    total_d   = total_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef CMD_ENC_ACK_TIMEOUT_EN
    ack_cnt_d = ack_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (cmd_known) begin
            state_d   = StSend;
            sr_d      = {req_command, operands};
            total_d   = cmd_total;
            cnt_d     = 3'd0;
`ifdef CMD_ENC_ACK_TIMEOUT_EN
            ack_cnt_d = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSend: begin
        if (next) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q + 3'd1 == total_q) begin
            state_d = StIdle;
            sr_d    = '0;
            done_d  = 1'b1;
          end else begin
            sr_d      = sr_q << 8;
`ifdef CMD_ENC_ACK_TIMEOUT_EN
            ack_cnt_d = '0;
`endif
          end
`ifdef CMD_ENC_ACK_TIMEOUT_EN
        end else if (ack_cnt_q == AckW'(ack_timeout - 1)) begin
          state_d = StIdle;
          sr_d    = '0;
          err_d   = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid = (state_q == StSend);
    req_ready = (state_q == StIdle);
    busy      = ~req_ready;
    out_byte  = sr_q[55:48];
    done      = done_q;
    req_error = err_q;
  end

endmodule

// File: tb/tb_control_cmd_encoder.sv
// Directed bench for control_cmd_encoder: narrow (256-block) and wide (512-block) instances.

`ifndef COMMAND_WRITE_BLOCK_INSTR
`define COMMAND_WRITE_BLOCK_INSTR   8'h01
`define COMMAND_WRITE_BLOCK_REG_0   8'h02
`define COMMAND_WRITE_BLOCK_REG_1   8'h03
`define COMMAND_ALLOC_DELAY         8'h04
`define COMMAND_SET_INPUT_GAIN      8'h05
`define COMMAND_SET_OUTPUT_GAIN     8'h06
`define COMMAND_BEGIN_PROGRAM       8'h07
`define COMMAND_END_PROGRAM         8'h08
`define COMMAND_COMMIT_REG_UPDATES  8'h09
`define COMMAND_UPDATE_BLOCK_REG_0  8'h0A
`define COMMAND_UPDATE_BLOCK_REG_1  8'h0B
`endif
`ifndef BLOCK_INSTR_WIDTH
`define BLOCK_INSTR_WIDTH 32
`endif

module tb_control_cmd_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [7:0]  req_command;
  logic [8:0]  req_block;
  logic [15:0] req_data;
  logic [31:0] req_instr;
  logic [31:0] req_delay_size;
  logic [31:0] req_init_delay;
  logic        next;
  logic        sel;

  logic       a_ready, a_valid, a_done, a_err, a_busy;
  logic [7:0] a_byte;
  logic       b_ready, b_valid, b_done, b_err, b_busy;
  logic [7:0] b_byte;

  logic       c_ready, c_valid, c_done, c_err, c_busy;
  logic [7:0] c_byte;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  control_cmd_encoder #(.n_blocks(256), .data_width(16), .ack_timeout(16)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid & ~sel),
    .req_ready      (a_ready),
    .req_command    (req_command),
    .req_block      (req_block[7:0]),
    .req_data       (req_data),
    .req_instr      (req_instr),
    .req_delay_size (req_delay_size),
    .req_init_delay (req_init_delay),
    .out_byte       (a_byte),
    .out_valid      (a_valid),
    .next           (next & ~sel),
    .done           (a_done),
    .req_error      (a_err),
    .busy           (a_busy)
  );

  control_cmd_encoder #(.n_blocks(512), .data_width(16), .ack_timeout(16)) u_dut_wide (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid & sel),
    .req_ready      (b_ready),
    .req_command    (req_command),
    .req_block      (req_block),
    .req_data       (req_data),
    .req_instr      (req_instr),
    .req_delay_size (req_delay_size),
    .req_init_delay (req_init_delay),
    .out_byte       (b_byte),
    .out_valid      (b_valid),
    .next           (next & sel),
    .done           (b_done),
    .req_error      (b_err),
    .busy           (b_busy)
  );

  assign c_ready = sel ? b_ready : a_ready;
  assign c_valid = sel ? b_valid : a_valid;
  assign c_done  = sel ? b_done  : a_done;
  assign c_err   = sel ? b_err   : a_err;
  assign c_busy  = sel ? b_busy  : a_busy;
  assign c_byte  = sel ? b_byte  : a_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then ack the first nack bytes, each after dly cycles of hold.
  task automatic send_cmd(input logic [7:0] cmd, input logic [8:0] blk, input logic [15:0] data,
                          input logic [31:0] instr, input logic [31:0] size,
                          input logic [31:0] init, input logic [55:0] expv, input int n,
                          input int nack, input int dly);
    int w = 0;
    while (!c_ready && w < 50) begin
      tick();
      w++;
    end
    check("ready_before_req", c_ready, 1);
    req_command    = cmd;
    req_block      = blk;
    req_data       = data;
    req_instr      = instr;
    req_delay_size = size;
    req_init_delay = init;
    req_valid      = 1'b1;
    tick();
    req_valid = 1'b0;
    check("done_clear_after_accept", c_done, 0);
    check("busy_after_accept", c_busy, 1);
    for (int i = 0; i < nack; i++) begin
      check("byte_valid", c_valid, 1);
      check("byte_value", c_byte, expv[55-8*i -: 8]);
      for (int d = 0; d < dly; d++) begin
        tick();
        check("hold_valid", c_valid, 1);
        check("hold_byte", c_byte, expv[55-8*i -: 8]);
        check("hold_no_done", c_done, 0);
      end
      next = 1'b1;
      tick();
      next = 1'b0;
      check("done_on_last", c_done, (i == n - 1) ? 1 : 0);
    end
    if (nack == n) begin
      check("end_valid_low", c_valid, 0);
      check("end_ready_high", c_ready, 1);
    end
  endtask

  initial begin
    int k;
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_command    = '0;
    req_block      = '0;
    req_data       = '0;
    req_instr      = '0;
    req_delay_size = '0;
    req_init_delay = '0;
    next           = 1'b0;
    sel            = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_ready", c_ready, 1);
    check("rst_valid", c_valid, 0);
    check("rst_byte", c_byte, 8'h00);
    check("rst_done", c_done, 0);
    check("rst_err", c_err, 0);
    check("rst_busy", c_busy, 0);

    send_cmd(`COMMAND_WRITE_BLOCK_INSTR, 9'h05, 16'h0, 32'hA1B2C3D4, 32'h0, 32'h0,
             {`COMMAND_WRITE_BLOCK_INSTR, 48'h05_A1B2C3D4_00}, 6, 6, 1);

    send_cmd(`COMMAND_ALLOC_DELAY, 9'h0, 16'h0, 32'h0, 32'h00123456, 32'h00000100,
             {`COMMAND_ALLOC_DELAY, 48'h123456_000100}, 7, 7, 1);
    send_cmd(`COMMAND_END_PROGRAM, 9'h0, 16'h0, 32'h0, 32'h0, 32'h0,
             {`COMMAND_END_PROGRAM, 48'h0}, 1, 1, 1);

    send_cmd(`COMMAND_SET_INPUT_GAIN, 9'h0, 16'h1234, 32'h0, 32'h0, 32'h0,
             {`COMMAND_SET_INPUT_GAIN, 48'h1234_0000_0000}, 3, 3, 1);
    send_cmd(`COMMAND_COMMIT_REG_UPDATES, 9'h0, 16'h0, 32'h0, 32'h0, 32'h0,
             {`COMMAND_COMMIT_REG_UPDATES, 48'h0}, 1, 1, 1);

    // Slow responder: each byte held 5 cycles before ack.
    send_cmd(`COMMAND_WRITE_BLOCK_REG_0, 9'h33, 16'hBEEF, 32'h0, 32'h0, 32'h0,
             {`COMMAND_WRITE_BLOCK_REG_0, 48'h33_BEEF_000000}, 4, 4, 5);

    tick();
    req_command = 8'hEE;
    req_valid   = 1'b1;
    tick();
    req_valid = 1'b0;
    check("unk_err_pulse", c_err, 1);
    check("unk_valid_low", c_valid, 0);
    check("unk_ready", c_ready, 1);
    tick();
    check("unk_err_clear", c_err, 0);
    check("unk_valid_still_low", c_valid, 0);

    // Reset after the second byte has been consumed.
    send_cmd(`COMMAND_WRITE_BLOCK_INSTR, 9'h05, 16'h0, 32'hA1B2C3D4, 32'h0, 32'h0,
             {`COMMAND_WRITE_BLOCK_INSTR, 48'h05_A1B2C3D4_00}, 6, 2, 1);
    check("mid_valid", c_valid, 1);
    check("mid_byte", c_byte, 8'hA1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_valid", c_valid, 0);
    check("abort_ready", c_ready, 1);
    check("abort_done", c_done, 0);
    check("abort_byte", c_byte, 8'h00);
    tick();
    check("abort_done_later", c_done, 0);
    check("abort_valid_later", c_valid, 0);

    sel = 1'b1;
    send_cmd(`COMMAND_UPDATE_BLOCK_REG_1, 9'h1FE, 16'h8001, 32'h0, 32'h0, 32'h0,
             {`COMMAND_UPDATE_BLOCK_REG_1, 48'h01FE_8001_0000}, 5, 5, 1);
    sel = 1'b0;

`ifdef CMD_ENC_ACK_TIMEOUT_EN
    send_cmd(`COMMAND_WRITE_BLOCK_INSTR, 9'h05, 16'h0, 32'hA1B2C3D4, 32'h0, 32'h0,
             {`COMMAND_WRITE_BLOCK_INSTR, 48'h05_A1B2C3D4_00}, 6, 2, 1);
    k = 0;
    while (!c_err && k < 40) begin
      tick();
      k++;
    end
    check("to_latency", 32'(k), 32'd16);
    check("to_valid", c_valid, 0);
    check("to_ready", c_ready, 1);
    check("to_no_done", c_done, 0);
    tick();
    check("to_err_clear", c_err, 0);
    send_cmd(`COMMAND_BEGIN_PROGRAM, 9'h0, 16'h0, 32'h0, 32'h0, 32'h0,
             {`COMMAND_BEGIN_PROGRAM, 48'h0}, 1, 1, 1);
`else
    k = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_cmd_encoder.md
Name: control_cmd_encoder

Overview:
- Byte-stream command serializer that feeds the control unit's byte-input interface (`out_byte`/`out_valid`, consumed via the control unit's `next` pulse).
- Takes one high-level command request per transaction, e.g. write instruction, write/update register, alloc delay, set gain, begin/end/commit.
- Emits the opcode byte, then the operand bytes in exactly the order and width the control unit's decoder expects.
- Sits between the on-chip host/bridge logic and the control unit; also serves as the stimulus driver in system benches.

Parameters:
- `n_blocks`, 256, block count; block field is 2 bytes if `n_blocks` > 256, else 1 byte.
- `data_width`, 16, register/gain data width; data field is 3 bytes if `data_width` == 24, else 2 bytes.
- `ack_timeout`, 1024, cycles to wait for `next` per byte (used only with the optional feature).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  command request present.
- `req_ready`  out  1  encoder idle; request accepted when `req_valid && req_ready`.
- `req_command`  in  8  opcode, one of the `COMMAND_*` defines from controller.vh.
- `req_block`  in  `$clog2(n_blocks)`  target block index.
- `req_data`  in  `data_width`  register or gain value.
- `req_instr`  in  `BLOCK_INSTR_WIDTH`  block instruction word.
- `req_delay_size`  in  `2*data_width`  delay buffer size; low 24 bits are sent.
- `req_init_delay`  in  `2*data_width`  initial delay; low 24 bits are sent.
- `out_byte`  out  8  current byte to the control unit.
- `out_valid`  out  1  `out_byte` is valid.
- `next`  in  1  control unit consumed `out_byte` (single-cycle pulse).
- `done`  out  1  one-cycle pulse when the last byte of a command is consumed.
- `req_error`  out  1  one-cycle pulse when an unknown opcode is rejected, or on timeout.
- `busy`  out  1  equals `~req_ready`.

Behaviour:
- Reset values: `req_ready`=1; `out_valid`=0; `out_byte`=0; `done`=0; `req_error`=0. State IDLE; byte counter 0; shift register 0.
- **States:** IDLE, SEND.
- **IDLE:**
  - On accept, latch all request fields.
  - Build a 56-bit shift register with the opcode in the top byte, then the operand bytes.
  - Set `bytes_total` = 1 + operand count; go to SEND with `out_valid`=1 and `out_byte`=opcode on the next cycle. Acceptance to first valid byte: 1 cycle.
- **Operand layout** (all fields MSB byte first):
  - `COMMAND_WRITE_BLOCK_INSTR`: block, then instr as 4 bytes.
  - `COMMAND_WRITE_BLOCK_REG_0/1` and `COMMAND_UPDATE_BLOCK_REG_0/1`: block, then data.
  - `COMMAND_ALLOC_DELAY`: delay_size as 3 bytes, then init_delay as 3 bytes.
  - `COMMAND_SET_INPUT_GAIN` / `COMMAND_SET_OUTPUT_GAIN`: data only.
  - `COMMAND_BEGIN_PROGRAM`, `COMMAND_COMMIT_REG_UPDATES`, `COMMAND_END_PROGRAM`: no operands.
  - Any other opcode: not sent; `req_error` pulses the cycle after accept; stay in IDLE.
- **SEND:**
  - `out_byte` and `out_valid` change only on an edge where `next`=1.
  - On `next`: shift left 8 bits and increment the counter.
  - If that byte was the last: `out_valid`<=0, `done`<=1, `req_ready`<=1, return to IDLE.
  - Otherwise, present the following byte on the next cycle. Steady state is one byte per 2 cycles, matching the control unit's `wait_one` hold-off.
- `next` while `out_valid`=0: ignored.
- `req_valid` while busy: not accepted; request fields are don't-care.
- `reset` mid-command: immediate abort to reset values; no further bytes are sent. The control unit's own timeout recovers its partial command.
- A new request may be accepted the cycle after `done` (back-to-back commands).
- Maximum transaction: 7 bytes (ALLOC_DELAY), or 7 for `WRITE_BLOCK_INSTR` with 2-byte block.

Optional Feature:
- Macro: `CMD_ENC_ACK_TIMEOUT_EN`.
- **Defined:** a per-byte counter clears whenever a byte is presented. If `next` is absent for `ack_timeout` cycles in SEND, the encoder aborts: `out_valid`<=0, `req_error` pulses, `req_ready`<=1, state IDLE, no `done`.
- **Undefined:** the counter is not built; SEND waits indefinitely for `next`.

Test Plan:
- **Instruction write:** `n_blocks`=256; `COMMAND_WRITE_BLOCK_INSTR`, block=0x05, instr=0xA1B2C3D4, responder acks every byte 1 cycle after valid → bytes `COMMAND_WRITE_BLOCK_INSTR`,05,A1,B2,C3,D4; `done` once, after byte 6.
- **Alloc delay:** `COMMAND_ALLOC_DELAY`, size=0x00123456, init=0x00000100 → opcode,12,34,56,00,01,00. Then `COMMAND_END_PROGRAM` requested the cycle after `done` → single opcode byte, no gap cycles lost.
- **Wide block field:** `n_blocks`=512, `data_width`=16; `COMMAND_UPDATE_BLOCK_REG_1`, block=0x1FE, data=0x8001 → opcode,01,FE,80,01.
- **Slow responder and unknown opcode:** `next` delayed 5 cycles per byte → `out_byte` stable and `out_valid` high until each `next`. Opcode 0xEE → `req_error` pulse, `out_valid` never asserted.
- **Reset mid-command:** assert `reset` after the 2nd byte of the instruction write → next cycle `out_valid`=0 and `req_ready`=1, no `done`.
- **Timeout** (`CMD_ENC_ACK_TIMEOUT_EN`, `ack_timeout`=16): stop `next` after byte 2 → `req_error` 16 cycles later, `out_valid`=0, next request accepted.
